// File: rtl/vdp_super_pkg.sv
// Shared types for the super-res VRAM write path: entry layout, FSM states, lane helper.
// No logic or latency of its own.
// No flow control of its own.
package vdp_super_pkg;

    localparam int VRAM_WORD_AW = 17;
    localparam int BYTE_AW      = 19;

    typedef struct packed {
        logic [BYTE_AW-1:0] addr;
        logic [7:0]         data;
    } wr_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        REQ
    } writer_state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/vdp_super_wr_fifo.sv
// Generic FIFO of wr_entry_t exposing the head and the next three entries for lookahead.
// Push visible to the reader one cycle later; peek outputs are combinational.
// Push is ignored when full unless a pop happens in the same cycle; pop_n entries retire at once.
module vdp_super_wr_fifo
    import vdp_super_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          push,
    input  wr_entry_t     push_dat,
    input  logic          pop,
    input  logic [2:0]    pop_n,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output wr_entry_t     peek [4]
);

    wr_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;
    logic            do_push;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_idx <= wr_idx + AW'(1);
            end
            if (pop) begin
                rd_idx <= rd_idx + AW'(pop_n);
            end
            count <= count + CW'(do_push) - (pop ? CW'(pop_n) : CW'(0));
        end
    end

    // Lookahead slots past the valid count hold stale data; consumers gate on count.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            peek[i] = mem[rd_idx + AW'(i)];
        end
    end

endmodule

// File: rtl/vdp_super_res_writer.sv
// CPU byte writer into super-res VRAM; masked 32-bit requests issued only while display fetch is idle (VDP_SUPER_WRITE_COALESCE_EN merges same-word bytes).
// Latency: byte accepted in cycle 0 raises vram_wr_req in cycle 2 when the bus is free.
// Backpressure: data_ready drops while the FIFO is full; the request is held until vram_wr_ack, withdrawn if drawing starts.
module vdp_super_res_writer
    import vdp_super_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    vdp_super,
    input  logic                    super_res_drawing,
    input  logic                    addr_wr,
    input  logic [BYTE_AW-1:0]      addr_in,
    input  logic                    data_wr,
    input  logic [7:0]              data_in,
    output logic                    data_ready,
    output logic                    busy,
    output logic                    vram_wr_req,
    output logic [VRAM_WORD_AW-1:0] vram_wr_addr,
    output logic [31:0]             vram_wr_data,
    output logic [3:0]              vram_wr_mask,
    input  logic                    vram_wr_ack
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    writer_state_t          state;
    writer_state_t          state_nxt;
    logic [BYTE_AW-1:0]     wr_ptr;
    logic [BYTE_AW-1:0]     ptr_base;
    logic                   accept;
    wr_entry_t              push_ent;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    wr_entry_t              peek [4];
    logic                   pop;
    logic [2:0]             req_n;
    logic                   form_load;
    logic [2:0]             form_off;
    logic [VRAM_WORD_AW-1:0] f_addr;
    logic [31:0]            f_data;
    logic [3:0]             f_mask;
    logic [2:0]             f_n;

    assign ptr_base   = addr_wr ? addr_in : wr_ptr;
    assign accept     = vdp_super && data_wr && data_ready;
    assign push_ent   = '{addr: ptr_base, data: data_in};
    assign data_ready = !fifo_full;
    assign vram_wr_req = (state == REQ);
    assign busy       = !fifo_empty || (state == REQ);

    vdp_super_wr_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (!vdp_super),
        .push     (accept),
        .push_dat (push_ent),
        .pop      (pop),
        .pop_n    (req_n),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .peek     (peek)
    );

    // Request formation from the entry at form_off (0, or the entry behind the one being popped).
    always_comb begin
        wr_entry_t h;
        h      = peek[form_off[1:0]];
        f_addr = h.addr[BYTE_AW-1:2];
        f_mask = lane_mask(h.addr[1:0]);
        f_data = {4{h.data}};
        f_n    = 3'd1;
`ifdef VDP_SUPER_WRITE_COALESCE_EN
        begin
            logic       stop;
            int         idx;
            logic [1:0] ln;
            stop = 1'b0;
            for (int k = 1; k < 4; k++) begin
                idx = int'(form_off) + k;
                ln  = peek[2'(idx)].addr[1:0];
                if (!stop && idx <= 3 && idx < int'(fifo_count) &&
                    peek[2'(idx)].addr[BYTE_AW-1:2] == f_addr && !f_mask[ln]) begin
                    f_mask             = f_mask | lane_mask(ln);
                    f_data[8*ln +: 8]  = peek[2'(idx)].data;
                    f_n                = f_n + 3'd1;
                end else begin
                    stop = 1'b1;
                end
            end
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        form_load = 1'b0;
        form_off  = 3'd0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (!super_res_drawing) begin
                        state_nxt = REQ;
                        form_load = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!super_res_drawing) begin
                    state_nxt = REQ;
                    form_load = 1'b1;
                end
            end
            REQ: begin
                if (vram_wr_ack) begin
                    pop = 1'b1;
                    // Chain only when the next head sits inside the lookahead window.
                    if (int'(fifo_count) > int'(req_n) && !super_res_drawing && req_n != 3'd4) begin
                        state_nxt = REQ;
                        form_load = 1'b1;
                        form_off  = req_n;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (super_res_drawing) begin
                    state_nxt = WAIT;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!vdp_super) begin
            state_nxt = IDLE;
            form_load = 1'b0;
            pop       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            vram_wr_addr <= '0;
            vram_wr_data <= '0;
            vram_wr_mask <= '0;
            req_n        <= 3'd1;
        end else if (!vdp_super) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            vram_wr_addr <= '0;
            vram_wr_data <= '0;
            vram_wr_mask <= '0;
            req_n        <= 3'd1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wr_ptr <= ptr_base + BYTE_AW'(1);
            end else if (addr_wr) begin
                wr_ptr <= addr_in;
            end
            if (form_load) begin
                vram_wr_addr <= f_addr;
                vram_wr_data <= f_data;
                vram_wr_mask <= f_mask;
                req_n        <= f_n;
            end
        end
    end

endmodule

// File: tb/tb_vdp_super_res_writer.sv
// Directed bench for vdp_super_res_writer; expectations follow VDP_SUPER_WRITE_COALESCE_EN when defined.
module tb_vdp_super_res_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vdp_super = 1'b1;
    logic        super_res_drawing = 1'b0;
    logic        addr_wr = 1'b0;
    logic [18:0] addr_in = '0;
    logic        data_wr = 1'b0;
    logic [7:0]  data_in = '0;
    logic        data_ready;
    logic        busy;
    logic        vram_wr_req;
    logic [16:0] vram_wr_addr;
    logic [31:0] vram_wr_data;
    logic [3:0]  vram_wr_mask;
    logic        vram_wr_ack = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vdp_super_res_writer #(.FIFO_DEPTH(4)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .vdp_super         (vdp_super),
        .super_res_drawing (super_res_drawing),
        .addr_wr           (addr_wr),
        .addr_in           (addr_in),
        .data_wr           (data_wr),
        .data_in           (data_in),
        .data_ready        (data_ready),
        .busy              (busy),
        .vram_wr_req       (vram_wr_req),
        .vram_wr_addr      (vram_wr_addr),
        .vram_wr_data      (vram_wr_data),
        .vram_wr_mask      (vram_wr_mask),
        .vram_wr_ack       (vram_wr_ack)
    );

    wire [53:0] req_bus = {vram_wr_req, vram_wr_addr, vram_wr_mask, vram_wr_data};

    // One byte strobe for one clock; back-to-back calls give consecutive pushes.
    task automatic push(input logic ld, input logic [18:0] a, input logic [7:0] d);
        addr_wr = ld;
        addr_in = a;
        data_wr = 1'b1;
        data_in = d;
        @(posedge clk) #1;
        addr_wr = 1'b0;
        data_wr = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (vram_wr_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack_pulse;
        vram_wr_ack = 1'b1;
        @(posedge clk) #1;
        vram_wr_ack = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        total++;
        if ({req_bus, data_ready, busy} !== {54'h0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got=%h ready=%b busy=%b want req_bus=0 ready=1 busy=0",
                     req_bus, data_ready, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_latency;
        @(posedge clk) #1;
        addr_wr = 1'b1; addr_in = 19'h00005; data_wr = 1'b1; data_in = 8'hAB;
        @(posedge clk) #1;
        addr_wr = 1'b0; data_wr = 1'b0;
        total++;
        if ({vram_wr_req, busy} !== 2'b01) begin
            bad++;
            $display("FAIL lat_cycle1 req/busy=%b want 01", {vram_wr_req, busy});
        end
        @(posedge clk) #1;
        total++;
        if (req_bus !== {1'b1, 17'h00001, 4'b0010, 32'hABABABAB}) begin
            bad++;
            $display("FAIL lat_cycle2 got=%h want=%h", req_bus, {1'b1, 17'h00001, 4'b0010, 32'hABABABAB});
        end
        ack_pulse();
        total++;
        if ({vram_wr_req, busy} !== 2'b00) begin
            bad++;
            $display("FAIL lat_after_ack req/busy=%b want 00", {vram_wr_req, busy});
        end
    endtask

    task automatic test_wrap;
        bit ok;
        super_res_drawing = 1'b1;
        push(1'b1, 19'h7FFFE, 8'h11);
        push(1'b0, 19'h0, 8'h22);
        push(1'b0, 19'h0, 8'h33);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({vram_wr_req, data_ready, busy} !== 3'b011) begin
            bad++;
            $display("FAIL wrap_hold req/ready/busy=%b want 011", {vram_wr_req, data_ready, busy});
        end
        super_res_drawing = 1'b0;
        wait_req(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL wrap_timeout req=0 want 1"); end
`ifdef VDP_SUPER_WRITE_COALESCE_EN
        total++;
        if (req_bus !== {1'b1, 17'h1FFFF, 4'b1100, 32'h22111111}) begin
            bad++;
            $display("FAIL wrap_w0 got=%h want=%h", req_bus, {1'b1, 17'h1FFFF, 4'b1100, 32'h22111111});
        end
        ack_pulse();
`else
        total++;
        if (req_bus !== {1'b1, 17'h1FFFF, 4'b0100, 32'h11111111}) begin
            bad++;
            $display("FAIL wrap_w0 got=%h want=%h", req_bus, {1'b1, 17'h1FFFF, 4'b0100, 32'h11111111});
        end
        ack_pulse();
        total++;
        if (req_bus !== {1'b1, 17'h1FFFF, 4'b1000, 32'h22222222}) begin
            bad++;
            $display("FAIL wrap_w1 got=%h want=%h", req_bus, {1'b1, 17'h1FFFF, 4'b1000, 32'h22222222});
        end
        ack_pulse();
`endif
        total++;
        if (req_bus !== {1'b1, 17'h00000, 4'b0001, 32'h33333333}) begin
            bad++;
            $display("FAIL wrap_w2 got=%h want=%h", req_bus, {1'b1, 17'h00000, 4'b0001, 32'h33333333});
        end
        ack_pulse();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL wrap_idle busy=%b want 0", busy); end
    endtask

    task automatic test_full;
        bit ok;
        super_res_drawing = 1'b1;
        push(1'b1, 19'h00200, 8'hA0);
        push(1'b0, 19'h0, 8'hA1);
        push(1'b0, 19'h0, 8'hA2);
        push(1'b0, 19'h0, 8'hA3);
        total++;
        if (data_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want 0", data_ready); end
        push(1'b0, 19'h0, 8'hA4);
        total++;
        if (data_ready !== 1'b0) begin bad++; $display("FAIL full_drop_ready got=%b want 0", data_ready); end
        super_res_drawing = 1'b0;
`ifdef VDP_SUPER_WRITE_COALESCE_EN
        wait_req(ok);
        total++;
        if (!ok || req_bus !== {1'b1, 17'h00080, 4'b1111, 32'hA3A2A1A0}) begin
            bad++;
            $display("FAIL full_drain got=%h want=%h", req_bus, {1'b1, 17'h00080, 4'b1111, 32'hA3A2A1A0});
        end
        ack_pulse();
`else
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'hA0 + 8'(i);
            wait_req(ok);
            total++;
            if (!ok || req_bus !== {1'b1, 17'h00080, 4'(1 << i), {4{b}}}) begin
                bad++;
                $display("FAIL full_drain%0d got=%h want=%h", i, req_bus, {1'b1, 17'h00080, 4'(1 << i), {4{b}}});
            end
            ack_pulse();
        end
`endif
        total++;
        if ({busy, data_ready} !== 2'b01) begin
            bad++;
            $display("FAIL full_empty busy/ready=%b want 01", {busy, data_ready});
        end
        push(1'b0, 19'h0, 8'hA5);
        wait_req(ok);
        total++;
        if (!ok || req_bus !== {1'b1, 17'h00081, 4'b0001, 32'hA5A5A5A5}) begin
            bad++;
            $display("FAIL full_ptr got=%h want=%h", req_bus, {1'b1, 17'h00081, 4'b0001, 32'hA5A5A5A5});
        end
        ack_pulse();
    endtask

    task automatic test_retry;
        bit ok;
        push(1'b1, 19'h00300, 8'h55);
        push(1'b1, 19'h00310, 8'h66);
        wait_req(ok);
        total++;
        if (!ok || req_bus !== {1'b1, 17'h000C0, 4'b0001, 32'h55555555}) begin
            bad++;
            $display("FAIL retry_first got=%h want=%h", req_bus, {1'b1, 17'h000C0, 4'b0001, 32'h55555555});
        end
        super_res_drawing = 1'b1;
        @(posedge clk) #1;
        total++;
        if (vram_wr_req !== 1'b0) begin bad++; $display("FAIL retry_drop req=%b want 0", vram_wr_req); end
        @(posedge clk) #1;
        total++;
        if ({vram_wr_req, busy} !== 2'b01) begin
            bad++;
            $display("FAIL retry_wait req/busy=%b want 01", {vram_wr_req, busy});
        end
        super_res_drawing = 1'b0;
        wait_req(ok);
        total++;
        if (!ok || req_bus !== {1'b1, 17'h000C0, 4'b0001, 32'h55555555}) begin
            bad++;
            $display("FAIL retry_reissue got=%h want=%h", req_bus, {1'b1, 17'h000C0, 4'b0001, 32'h55555555});
        end
        ack_pulse();
        total++;
        if (req_bus !== {1'b1, 17'h000C4, 4'b0001, 32'h66666666}) begin
            bad++;
            $display("FAIL retry_next got=%h want=%h", req_bus, {1'b1, 17'h000C4, 4'b0001, 32'h66666666});
        end
        // Ack coinciding with drawing rising still retires the write.
        vram_wr_ack = 1'b1;
        super_res_drawing = 1'b1;
        @(posedge clk) #1;
        vram_wr_ack = 1'b0;
        @(posedge clk) #1;
        total++;
        if ({vram_wr_req, busy} !== 2'b00) begin
            bad++;
            $display("FAIL retry_ack_draw req/busy=%b want 00", {vram_wr_req, busy});
        end
        super_res_drawing = 1'b0;
    endtask

    task automatic test_super_clear;
        bit ok;
        push(1'b1, 19'h00400, 8'h01);
        push(1'b1, 19'h00408, 8'h02);
        wait_req(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL clr_timeout req=0 want 1"); end
        vdp_super = 1'b0;
        @(posedge clk) #1;
        total++;
        if ({req_bus, busy, data_ready} !== {54'h0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL clr_state got=%h busy=%b ready=%b want 0/0/1", req_bus, busy, data_ready);
        end
        vdp_super = 1'b1;
        push(1'b0, 19'h0, 8'h77);
        wait_req(ok);
        total++;
        if (!ok || req_bus !== {1'b1, 17'h00000, 4'b0001, 32'h77777777}) begin
            bad++;
            $display("FAIL clr_ptr got=%h want=%h", req_bus, {1'b1, 17'h00000, 4'b0001, 32'h77777777});
        end
        ack_pulse();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL clr_drain busy=%b want 0", busy); end
    endtask

    task automatic test_coalesce;
        bit ok;
        super_res_drawing = 1'b1;
        push(1'b1, 19'h00100, 8'h11);
        push(1'b0, 19'h0, 8'h22);
        push(1'b0, 19'h0, 8'h33);
        push(1'b0, 19'h0, 8'h44);
        super_res_drawing = 1'b0;
`ifdef VDP_SUPER_WRITE_COALESCE_EN
        wait_req(ok);
        total++;
        if (!ok || req_bus !== {1'b1, 17'h00040, 4'b1111, 32'h44332211}) begin
            bad++;
            $display("FAIL coal_merge got=%h want=%h", req_bus, {1'b1, 17'h00040, 4'b1111, 32'h44332211});
        end
        ack_pulse();
`else
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'(8'h11 * (i + 1));
            wait_req(ok);
            total++;
            if (!ok || req_bus !== {1'b1, 17'h00040, 4'(1 << i), {4{b}}}) begin
                bad++;
                $display("FAIL coal_single%0d got=%h want=%h", i, req_bus, {1'b1, 17'h00040, 4'(1 << i), {4{b}}});
            end
            ack_pulse();
        end
`endif
        total++;
        if ({vram_wr_req, busy} !== 2'b00) begin
            bad++;
            $display("FAIL coal_done req/busy=%b want 00", {vram_wr_req, busy});
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_wrap();
        test_full();
        test_retry();
        test_super_clear();
        test_coalesce();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
